mc_ctrl_fsm: RTL and testbench

//  Multi-cycle control sequencer for the MIPS-subset CPU: FETCH/DECODE/EXEC/MEM/WB.

---
 rtl/mc_ctrl_pkg.sv | 59 +++++
 rtl/mc_ctrl_fsm_if.sv | 37 +++
 rtl/mc_alu_dec.sv | 27 ++
 rtl/mc_ctrl_fsm.sv | 179 +++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS-subset control path: ISA codes,
// ALUctr codes, state encodings and datapath mux selects.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_EXEC_I   = 4'd3,
    ST_WB_R     = 4'd4,
    ST_WB_I     = 4'd5,
    ST_MEM_ADDR = 4'd6,
    ST_MEM_RD   = 4'd7,
    ST_MEM_WR   = 4'd8,
    ST_WB_MEM   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11,
    ST_TRAP     = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  localparam logic [3:0] ALU_ADDU = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SUBU = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_LUI  = 4'b1000;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control/status bundle between the multi-cycle sequencer (master) and the
// datapath plus memory port (slave).
interface mc_ctrl_fsm_if;
  logic [5:0] op;
  logic [5:0] func;
  logic       zero;
  logic       ovf;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       i_or_d;
  logic       ir_wr;
  logic       pc_wr;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_ctr;
  logic       ext_op;
  logic       reg_wr;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       illegal;
  logic       bus_err;
  logic [3:0] state_o;

  modport master (
    input  op, func, zero, ovf, mem_ready,
    output mem_req, mem_we, i_or_d, ir_wr, pc_wr, pc_src, alu_src_a, alu_src_b,
           alu_ctr, ext_op, reg_wr, reg_dst, mem_to_reg, illegal, bus_err, state_o
  );

  modport slave (
    output op, func, zero, ovf, mem_ready,
    input  mem_req, mem_we, i_or_d, ir_wr, pc_wr, pc_src, alu_src_a, alu_src_b,
           alu_ctr, ext_op, reg_wr, reg_dst, mem_to_reg, illegal, bus_err, state_o
  );
endinterface

// File: rtl/mc_alu_dec.sv
// R-type func -> ALUctr decoder; func_valid flags the eight supported functions.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] func,
  output logic [3:0] alu_ctr,
  output logic       func_valid
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    alu_ctr    = ALU_ADDU;
    func_valid = 1'b1;
    case (func)
      FN_ADDU: alu_ctr = ALU_ADDU;
      FN_ADD:  alu_ctr = ALU_ADD;
      FN_AND:  alu_ctr = ALU_AND;
      FN_OR:   alu_ctr = ALU_OR;
      FN_SUBU: alu_ctr = ALU_SUBU;
      FN_SUB:  alu_ctr = ALU_SUB;
      FN_SLTU: alu_ctr = ALU_SLTU;
      FN_SLT:  alu_ctr = ALU_SLT;
      default: func_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with a shared memory port,
// request timeout trap and sticky illegal/bus_err flags.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int TMO_W   = 8,
  parameter int TMO_MAX = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  mc_ctrl_fsm_if.master bus
);

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TMO_MAX);

  state_e           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [TMO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;
  logic [3:0]       func_ctr;
  logic             func_valid;
  logic             timeout;

  mc_alu_dec u_alu_dec (
    .func       (bus.func),
    .alu_ctr    (func_ctr),
    .func_valid (func_valid)
  );

  assign timeout = (wait_cnt_q == TMO_LIMIT);

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    illegal_d      = illegal_q;
    bus_err_d      = bus_err_q;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.ir_wr      = 1'b0;
    bus.pc_wr      = 1'b0;
    bus.pc_src     = PC_SRC_ALU;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = SRCB_RT;
    bus.alu_ctr    = ALU_ADDU;
    bus.ext_op     = 1'b0;
    bus.reg_wr     = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.illegal    = 1'b0;
    bus.bus_err    = 1'b0;
    bus.state_o    = ST_FETCH;
    // While reset is held every output stays at its zero default.
    if (rst_n) begin
      bus.illegal = illegal_q;
      bus.bus_err = bus_err_q;
      bus.state_o = state_q;
      case (state_q)
        ST_FETCH: begin
          bus.mem_req   = 1'b1;
          bus.alu_src_b = SRCB_FOUR;
          if (bus.mem_ready) begin
            bus.ir_wr = 1'b1;
            bus.pc_wr = 1'b1;
            state_d   = ST_DECODE;
          end else if (timeout) begin
            state_d   = ST_TRAP;
            bus_err_d = 1'b1;
          end
        end
        ST_DECODE: begin
          bus.alu_src_b = SRCB_BR;
          bus.ext_op    = 1'b1;
          op_d          = bus.op;
          case (bus.op)
            OP_RTYPE:                         state_d = func_valid ? ST_EXEC_R : ST_TRAP;
            OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI: state_d = ST_EXEC_I;
            OP_LW, OP_SW:                     state_d = ST_MEM_ADDR;
            OP_BEQ:                           state_d = ST_BRANCH;
            OP_J:                             state_d = ST_JUMP;
            default:                          state_d = ST_TRAP;
          endcase
          if (state_d == ST_TRAP) illegal_d = 1'b1;
        end
        ST_EXEC_R, ST_WB_R: begin
          // ALU operands stay selected through write-back so ovf remains valid.
          bus.alu_src_a = 1'b1;
          bus.alu_ctr   = func_ctr;
          if (state_q == ST_EXEC_R) begin
            state_d = ST_WB_R;
          end else begin
            bus.reg_dst = 1'b1;
            bus.reg_wr  = !(bus.ovf && (func_ctr == ALU_ADD || func_ctr == ALU_SUB));
            state_d     = ST_FETCH;
          end
        end
        ST_EXEC_I, ST_WB_I: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = SRCB_IMM;
          case (op_q)
            OP_ADDI:  begin bus.alu_ctr = ALU_ADD;  bus.ext_op = 1'b1; end
            OP_ADDIU: begin bus.alu_ctr = ALU_ADDU; bus.ext_op = 1'b1; end
            OP_ORI:   bus.alu_ctr = ALU_OR;
            default:  bus.alu_ctr = ALU_LUI;
          endcase
          if (state_q == ST_EXEC_I) begin
            state_d = ST_WB_I;
          end else begin
            bus.reg_wr = !(bus.ovf && op_q == OP_ADDI);
            state_d    = ST_FETCH;
          end
        end
        ST_MEM_ADDR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = SRCB_IMM;
          bus.ext_op    = 1'b1;
          state_d       = (op_q == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
        end
        ST_MEM_RD, ST_MEM_WR: begin
          bus.mem_req = 1'b1;
          bus.i_or_d  = 1'b1;
          bus.mem_we  = (state_q == ST_MEM_WR);
          if (bus.mem_ready) begin
            state_d = (state_q == ST_MEM_RD) ? ST_WB_MEM : ST_FETCH;
          end else if (timeout) begin
            state_d   = ST_TRAP;
            bus_err_d = 1'b1;
          end
        end
        ST_WB_MEM: begin
          bus.reg_wr     = 1'b1;
          bus.mem_to_reg = 1'b1;
          state_d        = ST_FETCH;
        end
        ST_BRANCH: begin
          bus.alu_src_a = 1'b1;
          bus.alu_ctr   = ALU_SUBU;
          bus.pc_src    = PC_SRC_ALUOUT;
          bus.pc_wr     = bus.zero;
          state_d       = ST_FETCH;
        end
        ST_JUMP: begin
          bus.pc_src = PC_SRC_JUMP;
          bus.pc_wr  = 1'b1;
          state_d    = ST_FETCH;
        end
        ST_TRAP: state_d = ST_TRAP;
        default: state_d = ST_FETCH;
      endcase
    end
  end

  // Counts stalled request cycles in one state; saturates at the limit.
  always_comb begin
    wait_cnt_d = '0;
    if (bus.mem_req && !bus.mem_ready && state_d == state_q) begin
      wait_cnt_d = timeout ? wait_cnt_q : wait_cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, and sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      op_q       <= '0;
      wait_cnt_q <= '0;
      illegal_q  <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
      bus_err_q  <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Instruction-level bench for mc_ctrl_fsm: each instruction is predicted as a
// set of event counts and observed values, then compared after it retires.
module tb_mc_ctrl_fsm;
  import mc_ctrl_pkg::*;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mc_ctrl_fsm_if bus ();

  mc_ctrl_fsm #(.TMO_W(8), .TMO_MAX(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef enum {C_R, C_I, C_LW, C_SW, C_BEQ, C_J, C_BAD} cls_e;

  typedef struct {
    int         cycles;
    int         ir_wr;
    int         pc_wr;
    int         reg_wr;
    int         mem_we;
    int         data_req;
    int         fetch_req;
    logic [1:0] last_src;
    logic       reg_dst;
    logic       m2r;
    logic       illegal;
    logic       bus_err;
    logic       has_exec;
    logic       ext;
    logic [3:0] alu;
    logic [1:0] srcb;
  } exp_t;

  function automatic int alu_of_func(logic [5:0] f);
    case (f)
      FN_ADDU: return 0;
      FN_ADD:  return 1;
      FN_AND:  return 2;
      FN_OR:   return 3;
      FN_SUBU: return 4;
      FN_SUB:  return 5;
      FN_SLTU: return 6;
      FN_SLT:  return 7;
      default: return -1;
    endcase
  endfunction

  function automatic cls_e classify(logic [5:0] op, logic [5:0] func);
    case (op)
      OP_RTYPE: return (alu_of_func(func) < 0) ? C_BAD : C_R;
      OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI: return C_I;
      OP_LW:  return C_LW;
      OP_SW:  return C_SW;
      OP_BEQ: return C_BEQ;
      OP_J:   return C_J;
      default: return C_BAD;
    endcase
  endfunction

  // Expected behaviour of one instruction given the memory wait cycles fd (fetch) and md (data).
  function automatic exp_t model(logic [5:0] op, logic [5:0] func, int fd, int md, logic z, logic v);
    exp_t e;
    cls_e c;
    e = '{default: 0};
    c = classify(op, func);
    e.fetch_req = ((fd > TMO) ? TMO : fd) + 1;
    if (fd > TMO) begin
      e.cycles  = TMO + 1;
      e.bus_err = 1'b1;
      return e;
    end
    e.ir_wr = 1;
    e.pc_wr = 1;
    case (c)
      C_BAD: begin e.cycles = fd + 2; e.illegal = 1'b1; end
      C_R: begin
        e.cycles = fd + 4; e.has_exec = 1'b1; e.srcb = 2'b00; e.ext = 1'b0;
        e.alu = 4'(alu_of_func(func)); e.reg_dst = 1'b1;
        e.reg_wr = (v && (func == FN_ADD || func == FN_SUB)) ? 0 : 1;
      end
      C_I: begin
        e.cycles = fd + 4; e.has_exec = 1'b1; e.srcb = 2'b10;
        e.reg_wr = (v && op == OP_ADDI) ? 0 : 1;
        case (op)
          OP_ADDI:  begin e.alu = 4'b0001; e.ext = 1'b1; end
          OP_ADDIU: begin e.alu = 4'b0000; e.ext = 1'b1; end
          OP_ORI:   begin e.alu = 4'b0011; e.ext = 1'b0; end
          default:  begin e.alu = 4'b1000; e.ext = 1'b0; end
        endcase
      end
      C_LW, C_SW: begin
        e.has_exec = 1'b1; e.alu = 4'b0000; e.srcb = 2'b10; e.ext = 1'b1;
        if (md > TMO) begin
          e.cycles = fd + 3 + TMO + 1; e.bus_err = 1'b1; e.data_req = TMO + 1;
          e.mem_we = (c == C_SW) ? TMO + 1 : 0;
        end else if (c == C_LW) begin
          e.cycles = fd + 5 + md; e.data_req = md + 1; e.reg_wr = 1; e.m2r = 1'b1;
        end else begin
          e.cycles = fd + 4 + md; e.data_req = md + 1; e.mem_we = md + 1;
        end
      end
      C_BEQ: begin
        e.cycles = fd + 3; e.has_exec = 1'b1; e.alu = 4'b0100; e.srcb = 2'b00;
        if (z) begin e.pc_wr = 2; e.last_src = 2'b01; end
      end
      default: begin e.cycles = fd + 3; e.pc_wr = 2; e.last_src = 2'b10; end
    endcase
    return e;
  endfunction

  // Holds reset for exactly one rising edge; returns two time units after that edge.
  task automatic do_reset();
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    bus.op = OP_J;
    @(negedge clk);
    check("rst mem_req", bus.mem_req, 0);
    check("rst writes", {bus.ir_wr, bus.pc_wr, bus.reg_wr}, 0);
    check("rst flags", {bus.illegal, bus.bus_err}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.mem_ready = 1'b0;
    #1;
    check("post-rst mem_req", {bus.mem_req, bus.i_or_d}, 2'b10);
    check("post-rst flags", {bus.illegal, bus.bus_err}, 0);
    check("post-rst state", bus.state_o, ST_FETCH);
  endtask

  task automatic run_instr(input string nm, input logic [5:0] op, input logic [5:0] func,
                           input int fd, input int md, input logic z, input logic v);
    exp_t e;
    int cyc = 0, ir_n = 0, pc_n = 0, rw_n = 0, we_n = 0, dreq_n = 0, freq_n = 0, dec_cyc = -1;
    logic [1:0] last_src = 2'b00, srcb = 2'b00;
    logic [3:0] alu = 4'b0;
    logic rd = 1'b0, m2r = 1'b0, got_exec = 1'b0, ext = 1'b0;
    e = model(op, func, fd, md, z, v);
    bus.op = op; bus.func = func; bus.zero = z; bus.ovf = v;
    forever begin
      if ((ir_n > 0 && bus.mem_req && !bus.i_or_d) || bus.illegal || bus.bus_err) break;
      if (cyc >= 200) begin
        check({nm, " cycle budget"}, cyc, e.cycles);
        break;
      end
      // op is only meaningful during the decode cycle
      if (dec_cyc >= 0 && cyc > dec_cyc) bus.op = 6'($urandom);
      if (bus.mem_req && bus.i_or_d) begin
        bus.mem_ready = (dreq_n == md); dreq_n++;
      end else if (bus.mem_req) begin
        bus.mem_ready = (freq_n == fd); freq_n++;
      end else begin
        bus.mem_ready = 1'($urandom);
      end
      @(negedge clk);
      if (cyc == dec_cyc) begin
        check({nm, " decode mux"}, {bus.alu_src_a, bus.alu_src_b, bus.ext_op, bus.mem_req}, 5'b0_11_1_0);
      end
      if (ir_n == 0 && bus.mem_req && freq_n == 1) begin
        check({nm, " fetch mux"}, {bus.i_or_d, bus.alu_src_a, bus.alu_src_b, bus.alu_ctr}, 8'b0_0_01_0000);
      end
      if (bus.alu_src_a && !got_exec) begin
        got_exec = 1'b1; alu = bus.alu_ctr; srcb = bus.alu_src_b; ext = bus.ext_op;
      end
      if (bus.mem_we) we_n++;
      if (bus.pc_wr) begin pc_n++; last_src = bus.pc_src; end
      if (bus.reg_wr) begin rw_n++; rd = bus.reg_dst; m2r = bus.mem_to_reg; end
      if (bus.ir_wr) begin ir_n++; dec_cyc = cyc + 1; end
      @(posedge clk);
      #1 cyc++;
    end
    check({nm, " cycles"}, cyc, e.cycles);
    check({nm, " ir_wr"}, ir_n, e.ir_wr);
    check({nm, " pc_wr"}, pc_n, e.pc_wr);
    check({nm, " pc_src"}, last_src, e.last_src);
    check({nm, " reg_wr"}, rw_n, e.reg_wr);
    if (e.reg_wr > 0) check({nm, " wb mux"}, {rd, m2r}, {e.reg_dst, e.m2r});
    check({nm, " mem_we"}, we_n, e.mem_we);
    check({nm, " data req"}, dreq_n, e.data_req);
    check({nm, " fetch req"}, freq_n, e.fetch_req);
    if (e.has_exec) check({nm, " exec ctl"}, {got_exec, alu, srcb, ext}, {1'b1, e.alu, e.srcb, e.ext});
    check({nm, " flags"}, {bus.illegal, bus.bus_err}, {e.illegal, e.bus_err});
    if (e.illegal || e.bus_err) begin
      for (int k = 0; k < 3; k++) begin
        bus.mem_ready = 1'($urandom);
        @(negedge clk);
        check({nm, " trap hold"}, {bus.mem_req, bus.pc_wr, bus.reg_wr, bus.ir_wr, bus.illegal, bus.bus_err},
              {4'b0000, e.illegal, e.bus_err});
        @(posedge clk);
        #1;
      end
      check({nm, " trap state"}, bus.state_o, ST_TRAP);
      do_reset();
    end
  endtask

  logic [5:0] ops   [9] = '{OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI, OP_LW, OP_SW};
  logic [5:0] funcs [8] = '{FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_SLT, FN_SLTU};

  initial begin
    bus.op = '0; bus.func = '0; bus.zero = 1'b0; bus.ovf = 1'b0; bus.mem_ready = 1'b0;
    rst_n = 1'b0;
    do_reset();

    run_instr("add", OP_RTYPE, FN_ADD, 0, 0, 1'b0, 1'b0);
    run_instr("lw slow", OP_LW, 6'h00, 0, 3, 1'b0, 1'b0);
    run_instr("beq taken", OP_BEQ, 6'h00, 0, 0, 1'b1, 1'b0);
    run_instr("beq not", OP_BEQ, 6'h00, 0, 0, 1'b0, 1'b0);
    run_instr("bad op", 6'b111111, 6'h00, 0, 0, 1'b0, 1'b0);
    run_instr("bad func", OP_RTYPE, 6'b000111, 1, 0, 1'b0, 1'b0);
    run_instr("fetch tmo", OP_J, 6'h00, TMO + 1, 0, 1'b0, 1'b0);
    run_instr("fetch last", OP_RTYPE, FN_ADDU, TMO, 0, 1'b0, 1'b0);
    run_instr("addi ovf", OP_ADDI, 6'h00, 0, 0, 1'b0, 1'b1);
    run_instr("addiu ovf", OP_ADDIU, 6'h00, 0, 0, 1'b0, 1'b1);
    run_instr("sub ovf", OP_RTYPE, FN_SUB, 0, 0, 1'b0, 1'b1);
    run_instr("subu ovf", OP_RTYPE, FN_SUBU, 0, 0, 1'b0, 1'b1);
    run_instr("sw", OP_SW, 6'h00, 2, 2, 1'b0, 1'b0);
    run_instr("j", OP_J, 6'h00, 0, 0, 1'b0, 1'b0);
    run_instr("ori", OP_ORI, 6'h00, 0, 0, 1'b0, 1'b0);
    run_instr("lui", OP_LUI, 6'h00, 0, 0, 1'b0, 1'b0);
    run_instr("lw tmo", OP_LW, 6'h00, 0, TMO + 1, 1'b0, 1'b0);

    // Abort a load while its data request is outstanding.
    bus.op = OP_LW; bus.mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("abort in mem_rd", bus.state_o, ST_MEM_RD);
    do_reset();
    run_instr("after abort", OP_J, 6'h00, 0, 0, 1'b0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      logic [5:0] op, fn;
      int fd, md;
      op = ($urandom_range(0, 9) == 9) ? 6'($urandom) : ops[$urandom_range(0, 8)];
      fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : funcs[$urandom_range(0, 7)];
      fd = ($urandom_range(0, 19) == 0) ? TMO + 1 : $urandom_range(0, TMO);
      md = ($urandom_range(0, 19) == 0) ? TMO + 2 : $urandom_range(0, TMO);
      run_instr($sformatf("rnd%0d", n), op, fn, fd, md, 1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
